// File: rtl/riscv_pkg.sv
// Shared core-wide widths and the writeback entry payload (destination + data).
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order load-result buffer; every slot is visible so readers can forward
// from entries that have not reached the register file yet.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  wb_entry_t             i_push_ent,
  input  logic                  i_pop,
  output wb_entry_t             o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [PTR_W:0]        o_count,
  output logic [PTR_W-1:0]      o_rd_ptr,
  output wb_entry_t [DEPTH-1:0] o_ents
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_rd_ptr = r_rd_ptr;
  assign o_ents   = r_mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_ent;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: buffered loads drain ahead of ALU results,
// one registered write per cycle, with read-port forwarding of in-flight data.
module reg_writeback
  import riscv_pkg::*;
#(
  parameter int LSU_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [XLEN-1:0]       rs1_data_rf,
  input  logic [XLEN-1:0]       rs2_data_rf,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  pending
);

  localparam int PTR_W = $clog2(LSU_DEPTH);

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_alu_issue;
  logic                      w_issue;
  logic                      w_wr;
  wb_entry_t                 w_head;
  wb_entry_t                 w_issue_ent;
  wb_entry_t [LSU_DEPTH-1:0] w_ents;
  logic [PTR_W-1:0]          w_rd_ptr;
  logic [PTR_W:0]            w_count;

  logic                      r_we_p1;
  logic [REG_ADDR_W-1:0]     r_rd_p1;
  logic [XLEN-1:0]           r_rd_data_p1;

  // Scan oldest to youngest so the youngest buffered match wins; the
  // registered write and x0 then override in that order.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0]     rs,
    input logic [XLEN-1:0]           rf_data,
    input wb_entry_t [LSU_DEPTH-1:0] ents,
    input logic [PTR_W-1:0]          head,
    input logic [PTR_W:0]            cnt,
    input logic                      wb_we,
    input logic [REG_ADDR_W-1:0]     wb_rd,
    input logic [XLEN-1:0]           wb_data
  );
    logic [XLEN-1:0]  v;
    logic [PTR_W-1:0] idx;
    v = rf_data;
    for (int k = 0; k < LSU_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((k < int'(cnt)) && (ents[idx].rd == rs)) v = ents[idx].data;
    end
    if (wb_we && (wb_rd == rs)) v = wb_data;
    if (rs == '0) v = '0;
    return v;
  endfunction

  wb_fifo #(
    .DEPTH (LSU_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_ent ({lsu_rd, lsu_data}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_rd_ptr   (w_rd_ptr),
    .o_ents     (w_ents)
  );

  assign lsu_ready   = !w_full;
  assign alu_ready   = w_empty;
  assign pending     = !w_empty;
  assign w_push      = lsu_valid && !w_full;
  assign w_pop       = !w_empty;
  assign w_alu_issue = w_empty && alu_valid;
  assign w_issue     = w_pop || w_alu_issue;
  assign w_issue_ent = w_pop ? w_head : wb_entry_t'({alu_rd, alu_data});
  assign w_wr        = w_issue && (w_issue_ent.rd != '0);

  // p0 -> p1: issued entry registered onto the register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_p1      <= 1'b0;
      r_rd_p1      <= '0;
      r_rd_data_p1 <= '0;
    end else begin
      r_we_p1 <= w_wr;
      if (w_wr) begin
        r_rd_p1      <= w_issue_ent.rd;
        r_rd_data_p1 <= w_issue_ent.data;
      end
    end
  end

  assign we      = r_we_p1;
  assign rd      = r_rd_p1;
  assign rd_data = r_rd_data_p1;

  assign rs1_data = fwd_sel(rs1, rs1_data_rf, w_ents, w_rd_ptr, w_count,
                            r_we_p1, r_rd_p1, r_rd_data_p1);
  assign rs2_data = fwd_sel(rs2, rs2_data_rf, w_ents, w_rd_ptr, w_count,
                            r_we_p1, r_rd_p1, r_rd_data_p1);

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, reset corner case, then
// randomized traffic against a queue-based reference model.
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data, rd_data;
  logic [31:0] rs1_data_rf, rs2_data_rf, rs1_data, rs2_data;
  logic        we, pending;

  always #5 clk = ~clk;

  reg_writeback #(.LSU_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we(we), .rd(rd), .rd_data(rd_data),
    .rs1(rs1), .rs2(rs2), .rs1_data_rf(rs1_data_rf), .rs2_data_rf(rs2_data_rf),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pending(pending)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ardy, e_lrdy, e_pend;
    logic [31:0] e_r1, e_r2;
    logic        e_we, chk_rd;
    logic [4:0]  e_rd; logic [31:0] e_data;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rf_m [32];
  ent_t        q [$];
  logic        m_we, n_we;
  logic [4:0]  m_rd, n_rd;
  logic [31:0] m_data, n_data;
  vec_t        tv [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (m_we && m_rd == rs) return m_data;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rs) return q[i].data;
    return rf_m[rs];
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic apply(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    rs1 = r1; rs2 = r2;
    rs1_data_rf = rf_m[r1]; rs2_data_rf = rf_m[r2];
    #1;
  endtask

  // One write per cycle: drain the oldest load first, else take the ALU.
  task automatic edge_step();
    ent_t e;
    logic iss, lrdy;
    e = '0; iss = 1'b0;
    lrdy = (q.size() < DEPTH);
    if (q.size() > 0) begin
      e = q.pop_front(); iss = 1'b1;
    end else if (alu_valid) begin
      e = '{alu_rd, alu_data}; iss = 1'b1;
    end
    if (lsu_valid && lrdy) q.push_back('{lsu_rd, lsu_data});
    n_we = iss && (e.rd != 5'd0); n_rd = e.rd; n_data = e.data;
    @(posedge clk);
    if (m_we) rf_m[m_rd] = m_data;
    m_we = n_we;
    if (n_we) begin m_rd = n_rd; m_data = n_data; end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    model_reset();
    //         av ard   ad            lv lrd    ld            r1     r2     ardy lrdy pend  e_r1          e_r2          we chk rd     data
    tv[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 1, 0, 32'h0,        32'h0,        1, 1, 5'd5,  32'hDEADBEEF};
    tv[1]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd5,  5'd0,  1, 1, 0, 32'hDEADBEEF, 32'h0,        0, 1, 5'd5,  32'hDEADBEEF};
    tv[2]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd5,  5'd5,  1, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 5'd0,  32'h0};
    tv[3]  = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,        5'd0,  5'd5,  1, 1, 0, 32'h0,        32'hDEADBEEF, 0, 0, 5'd0,  32'h0};
    tv[4]  = '{0, 5'd0, 32'h0,        1, 5'd3,  32'h11111111, 5'd3,  5'd0,  1, 1, 0, 32'h0,        32'h0,        0, 0, 5'd0,  32'h0};
    tv[5]  = '{1, 5'd4, 32'h44444444, 0, 5'd0,  32'h0,        5'd3,  5'd4,  0, 1, 1, 32'h11111111, 32'h0,        1, 1, 5'd3,  32'h11111111};
    tv[6]  = '{1, 5'd4, 32'h44444444, 0, 5'd0,  32'h0,        5'd3,  5'd4,  1, 1, 0, 32'h11111111, 32'h0,        1, 1, 5'd4,  32'h44444444};
    tv[7]  = '{0, 5'd0, 32'h0,        1, 5'd10, 32'hA0A0A0A0, 5'd4,  5'd3,  1, 1, 0, 32'h44444444, 32'h11111111, 0, 0, 5'd0,  32'h0};
    tv[8]  = '{0, 5'd0, 32'h0,        1, 5'd11, 32'hB1B1B1B1, 5'd10, 5'd11, 0, 1, 1, 32'hA0A0A0A0, 32'h0,        1, 1, 5'd10, 32'hA0A0A0A0};
    tv[9]  = '{0, 5'd0, 32'h0,        1, 5'd12, 32'hC2C2C2C2, 5'd11, 5'd10, 0, 1, 1, 32'hB1B1B1B1, 32'hA0A0A0A0, 1, 1, 5'd11, 32'hB1B1B1B1};
    tv[10] = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd12, 5'd11, 0, 1, 1, 32'hC2C2C2C2, 32'hB1B1B1B1, 1, 1, 5'd12, 32'hC2C2C2C2};
    tv[11] = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd12, 5'd10, 1, 1, 0, 32'hC2C2C2C2, 32'hA0A0A0A0, 0, 1, 5'd12, 32'hC2C2C2C2};
    tv[12] = '{0, 5'd0, 32'h0,        1, 5'd7,  32'h12345678, 5'd7,  5'd0,  1, 1, 0, 32'h0,        32'h0,        0, 0, 5'd0,  32'h0};
    tv[13] = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd7,  5'd7,  0, 1, 1, 32'h12345678, 32'h12345678, 1, 1, 5'd7,  32'h12345678};
    tv[14] = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd7,  5'd0,  1, 1, 0, 32'h12345678, 32'h0,        0, 0, 5'd0,  32'h0};
    tv[15] = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        5'd7,  5'd12, 1, 1, 0, 32'h12345678, 32'hC2C2C2C2, 0, 0, 5'd0,  32'h0};

    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    rs1 = 0; rs2 = 0; rs1_data_rf = 0; rs2_data_rf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", we, 0);
    chk("reset_rd", rd, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_pending", pending, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_lsu_ready", lsu_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(tv[i].av, tv[i].ard, tv[i].ad, tv[i].lv, tv[i].lrd, tv[i].ld, tv[i].r1, tv[i].r2);
      chk($sformatf("v%0d_alu_ready", i), alu_ready, tv[i].e_ardy);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, tv[i].e_lrdy);
      chk($sformatf("v%0d_pending", i), pending, tv[i].e_pend);
      chk($sformatf("v%0d_rs1_data", i), rs1_data, tv[i].e_r1);
      chk($sformatf("v%0d_rs2_data", i), rs2_data, tv[i].e_r2);
      edge_step();
      chk($sformatf("v%0d_we", i), we, tv[i].e_we);
      if (tv[i].chk_rd) begin
        chk($sformatf("v%0d_rd", i), rd, tv[i].e_rd);
        chk($sformatf("v%0d_rd_data", i), rd_data, tv[i].e_data);
      end
    end

    // Reset pulse between edges with one load still buffered and a write on the port.
    apply(0, 5'd0, 32'h0, 1, 5'd8, 32'h88888888, 5'd0, 5'd0);
    edge_step();
    apply(0, 5'd0, 32'h0, 1, 5'd9, 32'h99999999, 5'd0, 5'd0);
    edge_step();
    chk("pre_rst_we", we, 1);
    chk("pre_rst_rd", rd, 5'd8);
    chk("pre_rst_pending", pending, 1);
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd8);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_alu_ready", alu_ready, 1);
    chk("mid_rst_lsu_ready", lsu_ready, 1);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd8);
      chk($sformatf("post_rst%0d_rs1", i), rs1_data, rf_m[9]);
      edge_step();
      chk($sformatf("post_rst%0d_we", i), we, 0);
      chk($sformatf("post_rst%0d_pending", i), pending, 0);
    end

    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      chk("rnd_alu_ready", alu_ready, q.size() == 0);
      chk("rnd_lsu_ready", lsu_ready, q.size() < DEPTH);
      chk("rnd_pending", pending, q.size() != 0);
      chk("rnd_rs1_data", rs1_data, m_fwd(rs1));
      chk("rnd_rs2_data", rs2_data, m_fwd(rs2));
      edge_step();
      chk("rnd_we", we, m_we);
      if (m_we) begin
        chk("rnd_rd", rd, m_rd);
        chk("rnd_rd_data", rd_data, m_data);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter: LSU_DEPTH, default 2, number of buffered load-result entries (power of two, >=2).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 alu_valid  in  1  ALU writeback request present.
REQ-005 alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  32  ALU result.
REQ-008 lsu_valid  in  1  load-result writeback request present.
REQ-009 lsu_ready  out  1  load request accepted this cycle when high with lsu_valid.
REQ-010 lsu_rd  in  5  load destination register.
REQ-011 lsu_data  in  32  load result.
REQ-012 we  out  1  register_file write enable (registered).
REQ-013 rd  out  5  register_file write address (registered).
REQ-014 rd_data  out  32  register_file write data (registered).
REQ-015 rs1, rs2  in  5 each  read addresses presented to register_file.
REQ-016 rs1_data_rf, rs2_data_rf  in  32 each  raw register_file read data.
REQ-017 rs1_data, rs2_data  out  32 each  forwarded read data.
REQ-018 pending  out  1  high while load buffer non-empty.

Function
REQ-019 Load requests SHALL be pushed into an in-order FIFO of LSU_DEPTH entries; lsu_ready = !full, independent of a same-cycle pop.
REQ-020 Issue priority: FIFO head first; ALU request only when FIFO empty; alu_ready = FIFO empty.
REQ-021 At most one write SHALL be issued per cycle; the issued entry is registered onto we/rd/rd_data at the next rising edge.
REQ-022 Latency: ALU accepted at edge N -> we high in cycle after edge N; load pushed at edge N into empty FIFO -> we high in cycle after edge N+1.
REQ-023 No issue in a cycle -> we=0 next cycle; rd/rd_data hold previous values.
REQ-024 Requests with rd=0 SHALL complete the handshake and leave the FIFO normally but SHALL produce we=0.
REQ-025 FIFO push and pop in the same cycle SHALL both occur; count unchanged; pointers wrap modulo LSU_DEPTH.
REQ-026 Forwarding, per read port, priority order: rsX==0 -> 0; we && rd==rsX -> rd_data; youngest FIFO entry with matching rd -> its data; else rsX_data_rf. Purely combinational.
REQ-027 pending = (FIFO count != 0).

Reset
REQ-028 While rst is high: we=0, rd=0, rd_data=0, FIFO empty, pending=0, alu_ready=1, lsu_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered loads and any not-yet-registered issue; no write occurs after rst rises.

Structure
REQ-030 Shared package riscv_pkg SHALL hold XLEN=32 and REG_ADDR_W=5; this block imports them.
REQ-031 One sub-module wb_fifo (parametric depth, data+rd payload, exposes all entries for forwarding lookup).
REQ-032 Arbiter, output register and forwarding mux SHALL reside in reg_writeback.

Verification
REQ-033 ALU rd=5 data=0xDEADBEEF, FIFO empty -> next cycle we=1 rd=5 rd_data=0xDEADBEEF; register_file read of x5 afterwards returns 0xDEADBEEF.
REQ-034 Load rd=3 0x11111111, same cycle ALU rd=4 valid -> alu_ready=0 until x3 issued; writes in order x3 then x4.
REQ-035 Three back-to-back loads with LSU_DEPTH=2 and ALU idle -> lsu_ready deasserts once FIFO full; all three written in order, none lost.
REQ-036 ALU rd=0 data=0xFFFFFFFF -> alu_ready=1, we stays 0; rs1=0 reads 0.
REQ-037 Load rd=7 0x12345678 buffered, rs1=7 with rs1_data_rf=0 -> rs1_data=0x12345678 before and during write cycle.
REQ-038 Two loads buffered, rst pulsed between edges -> we=0 immediately, pending=0, no writes after release.
